// File: rtl/pipe_gen_multi.sv
// Multi-pipe obstacle generator: scrolls NUM_PIPES pipes left each frame, respawns them
// with LFSR gap heights and reports passes. Optional speed ramp: PIPE_GEN_SPEED_RAMP_EN.
module pipe_gen_multi #(
  parameter int NUM_PIPES       = 3,
  parameter int X_W             = 12,
  parameter int PIPE_START_X    = 600,
  parameter int PIPE_DIST       = 300,
  parameter int PIPE_W          = 80,
  parameter int BIRD_X          = 300,
  parameter int GAP_MIN         = 200,
  parameter int GAP_RANGE       = 300,
  parameter int SPEED_INIT      = 3,
  parameter int SPEED_MAX       = 8,
  parameter int SCORE_PER_LEVEL = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       game_active,
  input  logic                       frame_en,
  input  logic                       seed_load,
  input  logic [15:0]                seed,
  output logic [NUM_PIPES*X_W-1:0]   pipe_x,
  output logic [NUM_PIPES*X_W-1:0]   pipe_gap_y,
  output logic                       score_pulse,
  output logic [3:0]                 pass_count,
  output logic [3:0]                 speed
);

  localparam int              SW        = X_W + 1;
  localparam logic [X_W-1:0]  TH        = X_W'(BIRD_X - PIPE_W);
  localparam logic [X_W-1:0]  GAP_INIT  = X_W'(GAP_MIN + (GAP_RANGE >> 1));
  localparam logic [SW-1:0]   WRAP      = SW'(NUM_PIPES * PIPE_DIST);
  localparam logic [3:0]      SPEED_RST = 4'(SPEED_INIT);
  localparam logic [15:0]     LFSR_RST  = 16'hACE1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  function automatic logic [X_W-1:0] start_x(input int i);
    return X_W'(SW'(PIPE_START_X) + SW'(i * PIPE_DIST));
  endfunction

  // Gap for pipe i: low 9 bits of the LFSR rotated left by 3*i, folded into GAP_RANGE.
  function automatic logic [X_W-1:0] gap_for(input logic [15:0] l, input int i);
    int         s;
    logic [8:0] v;
    logic [8:0] r;
    s = (3 * i) % 16;
    v = 9'((l << s) | (l >> (16 - s)));
    r = (v >= 9'(GAP_RANGE)) ? v - 9'(GAP_RANGE) : v;
    return X_W'(SW'(GAP_MIN) + SW'(r));
  endfunction

  function automatic logic [X_W-1:0] respawn_x(input logic [X_W-1:0] x, input logic [3:0] spd);
    return X_W'(SW'(x) + WRAP - SW'(spd));
  endfunction

  function automatic logic [3:0] count_ones(input logic [NUM_PIPES-1:0] b);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < NUM_PIPES; i++) c = c + 4'(b[i]);
    return c;
  endfunction

  state_t                state_q, state_d;
  logic                  restore, advance;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [X_W-1:0]        x_q   [NUM_PIPES];
  logic [X_W-1:0]        x_d   [NUM_PIPES];
  logic [X_W-1:0]        gap_q [NUM_PIPES];
  logic [X_W-1:0]        gap_d [NUM_PIPES];
  logic [NUM_PIPES-1:0]  pass_v;
  logic [3:0]            npass;
  logic                  score_q, score_d;
  logic [3:0]            pcount_q, pcount_d;
  logic [3:0]            speed_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (game_active)  state_d = RUN;
      RUN:     if (!game_active) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Leaving RUN restores the layout on the same edge; motion only happens in RUN.
  always_comb begin
    restore = (state_q == RUN) && !game_active;
    advance = (state_q == RUN) && game_active && frame_en;
  end

  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_load)     lfsr_d = (seed == 16'h0000) ? LFSR_RST : seed;
    else if (frame_en) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_RST;
    else     lfsr_q <= lfsr_d;
  end

  always_comb begin
    for (int i = 0; i < NUM_PIPES; i++) begin
      x_d[i]    = x_q[i];
      gap_d[i]  = gap_q[i];
      pass_v[i] = 1'b0;
      if (restore) begin
        x_d[i]   = start_x(i);
        gap_d[i] = GAP_INIT;
      end else if (advance) begin
        if (x_q[i] < X_W'(speed_q)) begin
          x_d[i]   = respawn_x(x_q[i], speed_q);
          gap_d[i] = gap_for(lfsr_q, i);
        end else begin
          x_d[i]    = x_q[i] - X_W'(speed_q);
          pass_v[i] = (x_q[i] >= TH) && (x_d[i] < TH);
        end
      end
    end
    npass    = count_ones(pass_v);
    score_d  = |pass_v;
    pcount_d = score_d ? npass : 4'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_q[i]   <= start_x(i);
        gap_q[i] <= GAP_INIT;
      end
      score_q  <= 1'b0;
      pcount_q <= 4'd0;
    end else begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_q[i]   <= x_d[i];
        gap_q[i] <= gap_d[i];
      end
      score_q  <= score_d;
      pcount_q <= pcount_d;
    end
  end

`ifdef PIPE_GEN_SPEED_RAMP_EN
  localparam int LW = $clog2(SCORE_PER_LEVEL + 16);

  logic [LW-1:0] lvl_q, lvl_d, lvl_sum;
  logic [3:0]    speed_d;

  // Passes are counted modulo SCORE_PER_LEVEL; each wrap bumps the speed for the next frame.
  always_comb begin
    speed_d = speed_q;
    lvl_d   = lvl_q;
    lvl_sum = lvl_q + LW'(npass);
    if (restore) begin
      speed_d = SPEED_RST;
      lvl_d   = '0;
    end else if (advance) begin
      if (lvl_sum >= LW'(SCORE_PER_LEVEL)) begin
        lvl_d = lvl_sum - LW'(SCORE_PER_LEVEL);
        if (speed_q < 4'(SPEED_MAX)) speed_d = speed_q + 4'd1;
      end else begin
        lvl_d = lvl_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      speed_q <= SPEED_RST;
      lvl_q   <= '0;
    end else begin
      speed_q <= speed_d;
      lvl_q   <= lvl_d;
    end
  end
`else
  assign speed_q = SPEED_RST;
`endif

  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pack
    assign pipe_x[g*X_W +: X_W]     = x_q[g];
    assign pipe_gap_y[g*X_W +: X_W] = gap_q[g];
  end

  assign score_pulse = score_q;
  assign pass_count  = pcount_q;
  assign speed       = speed_q;

endmodule

// File: tb/tb_pipe_gen_multi.sv
// Bench for pipe_gen_multi: directed vector table, hand-built respawn/seed sequences and
// randomized traffic compared every cycle against an arithmetic reference model.
module tb_pipe_gen_multi;

  localparam int N      = 3;
  localparam int XW     = 12;
  localparam int START  = 600;
  localparam int DIST   = 300;
  localparam int TH     = 300 - 80;
  localparam int GMIN   = 200;
  localparam int GRANGE = 300;
  localparam int SINIT  = 3;
  localparam int SMAX   = 8;
  localparam int SPL    = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, game_active, frame_en, seed_load;
  logic [15:0]       seed;
  logic [N*XW-1:0]   pipe_x, pipe_gap_y;
  logic              score_pulse;
  logic [3:0]        pass_count, speed;

  pipe_gen_multi dut (
    .clk        (clk),
    .rst        (rst),
    .game_active(game_active),
    .frame_en   (frame_en),
    .seed_load  (seed_load),
    .seed       (seed),
    .pipe_x     (pipe_x),
    .pipe_gap_y (pipe_gap_y),
    .score_pulse(score_pulse),
    .pass_count (pass_count),
    .speed      (speed)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state, plain integers.
  int mx [N];
  int mg [N];
  int mspeed, mpulse, mcount, ml, mtotal;
  bit mrun;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] xof(input int i);
    return 64'(pipe_x[i*XW +: XW]);
  endfunction

  function automatic logic [63:0] gof(input int i);
    return 64'(pipe_gap_y[i*XW +: XW]);
  endfunction

  function automatic int gap_model(input int l, input int i);
    int s, v;
    s = (3 * i) % 16;
    v = (((l << s) | (l >> (16 - s))) & 16'hFFFF) % 512;
    if (v >= GRANGE) v = v - GRANGE;
    return GMIN + v;
  endfunction

  function automatic void model_layout();
    for (int i = 0; i < N; i++) begin
      mx[i] = START + i * DIST;
      mg[i] = GMIN + GRANGE / 2;
    end
    mspeed = SINIT;
    mtotal = 0;
  endfunction

  function automatic void model_step(input bit r, input bit ga, input bit fe, input bit sl, input int sd);
    int old_l, n, nx, old_t;
    if (r) begin
      model_layout();
      mpulse = 0;
      mcount = 0;
      ml     = 16'hACE1;
      mrun   = 0;
      return;
    end
    old_l = ml;
    if (sl)      ml = (sd == 0) ? 16'hACE1 : sd;
    else if (fe) ml = ((ml << 1) | (((ml >> 15) ^ (ml >> 13) ^ (ml >> 12) ^ (ml >> 10)) & 1)) & 16'hFFFF;
    mpulse = 0;
    mcount = 0;
    if (mrun && !ga) begin
      mrun = 0;
      model_layout();
    end else if (mrun && fe) begin
      n = 0;
      for (int i = 0; i < N; i++) begin
        if (mx[i] < mspeed) begin
          mx[i] = (mx[i] + N * DIST - mspeed) % (1 << XW);
          mg[i] = gap_model(old_l, i);
        end else begin
          nx = mx[i] - mspeed;
          if (mx[i] >= TH && nx < TH) n++;
          mx[i] = nx;
        end
      end
      mpulse = (n > 0) ? 1 : 0;
      mcount = n;
`ifdef PIPE_GEN_SPEED_RAMP_EN
      old_t  = mtotal;
      mtotal = mtotal + n;
      if ((mtotal / SPL) != (old_t / SPL) && mspeed < SMAX) mspeed++;
`else
      old_t = 0;
`endif
    end else if (!mrun && ga) begin
      mrun = 1;
    end
  endfunction

  task automatic cmp_model();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("model_x%0d", i), xof(i), 64'(mx[i]));
      chk($sformatf("model_gap%0d", i), gof(i), 64'(mg[i]));
    end
    chk("model_pulse", 64'(score_pulse), 64'(mpulse));
    chk("model_count", 64'(pass_count), 64'(mcount));
    chk("model_speed", 64'(speed), 64'(mspeed));
  endtask

  task automatic cyc(input logic r, input logic ga, input logic fe, input logic sl, input logic [15:0] sd);
    rst = r; game_active = ga; frame_en = fe; seed_load = sl; seed = sd;
    model_step(r, ga, fe, sl, int'(sd));
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  typedef struct {
    logic r, ga, fe;
    int   rep;
    int   x0, x1, x2;
    int   pl, pc;
  } vec_t;

  vec_t tbl [11];

  initial begin
    rst = 1'b1; game_active = 1'b0; frame_en = 1'b0; seed_load = 1'b0; seed = 16'h0;

    tbl[0]  = '{1'b1, 1'b0, 1'b0,   2, 600, 900, 1200, 0, 0};  // reset
    tbl[1]  = '{1'b1, 1'b0, 1'b1,   1, 600, 900, 1200, 0, 0};  // frame_en under rst
    tbl[2]  = '{1'b0, 1'b1, 1'b0,   1, 600, 900, 1200, 0, 0};  // IDLE -> RUN
    tbl[3]  = '{1'b0, 1'b1, 1'b1,   1, 597, 897, 1197, 0, 0};  // first frame
    tbl[4]  = '{1'b0, 1'b1, 1'b0,   3, 597, 897, 1197, 0, 0};  // no frame, hold
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 125, 222, 522,  822, 0, 0};  // frame 126
    tbl[6]  = '{1'b0, 1'b1, 1'b1,   1, 219, 519,  819, 1, 1};  // frame 127: pass
    tbl[7]  = '{1'b0, 1'b1, 1'b0,   1, 219, 519,  819, 0, 0};  // pulse lasts one clk
    tbl[8]  = '{1'b0, 1'b1, 1'b1,  73,   0, 300,  600, 0, 0};  // frame 200
    tbl[9]  = '{1'b0, 1'b1, 1'b1,   1, 897, 297,  597, 0, 0};  // respawn keeps spacing
    tbl[10] = '{1'b0, 1'b0, 1'b0,   1, 600, 900, 1200, 0, 0};  // drop game_active

    for (int k = 0; k < 11; k++) begin
      for (int j = 0; j < tbl[k].rep; j++) cyc(tbl[k].r, tbl[k].ga, tbl[k].fe, 1'b0, 16'h0);
      chk($sformatf("tbl%0d_x0", k), xof(0), 64'(tbl[k].x0));
      chk($sformatf("tbl%0d_x1", k), xof(1), 64'(tbl[k].x1));
      chk($sformatf("tbl%0d_x2", k), xof(2), 64'(tbl[k].x2));
      chk($sformatf("tbl%0d_pulse", k), 64'(score_pulse), 64'(tbl[k].pl));
      chk($sformatf("tbl%0d_count", k), 64'(pass_count), 64'(tbl[k].pc));
      chk($sformatf("tbl%0d_speed", k), 64'(speed), 64'(SINIT));
      if (k == 9) begin
        chk("respawn_gap_in_range", 64'((gof(0) >= 200) && (gof(0) <= 499)), 64'(1));
      end
    end

    // Seed-load sequence: seed 0 gives ACE1, and seed_load beats a coincident frame_en.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    repeat (199) cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
    chk("seq_x0_at_zero", xof(0), 64'(0));
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("seq_x0_respawn", xof(0), 64'(897));
    chk("seq_gap0_ace1", gof(0), 64'(425));
    repeat (98) cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h01FF);
    chk("seq_x1_at_zero", xof(1), 64'(0));
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("seq_x0", xof(0), 64'(597));
    chk("seq_x1_respawn", xof(1), 64'(897));
    chk("seq_x2", xof(2), 64'(297));
    chk("seq_gap1_fold", gof(1), 64'(404));
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("seq_restore_x1", xof(1), 64'(900));
    chk("seq_restore_gap1", gof(1), 64'(350));
    chk("seq_restore_speed", 64'(speed), 64'(SINIT));

    // Randomized traffic against the model.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    for (int k = 0; k < 3000; k++) begin
      logic        r, ga, fe, sl;
      logic [15:0] sd;
      r  = ($urandom_range(0, 1499) == 0);
      ga = ($urandom_range(0, 999) != 0);
      fe = ($urandom_range(0, 3) != 0);
      sl = ($urandom_range(0, 63) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      cyc(r, ga, fe, sl, sd);
    end

`ifdef PIPE_GEN_SPEED_RAMP_EN
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    repeat (2500) cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("ramp_saturated", 64'(speed), 64'(SMAX));
    repeat (200) cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("ramp_still_saturated", 64'(speed), 64'(SMAX));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_gen_multi.md
Name: pipe_gen_multi

Overview:
- Parametrised successor to the two-pipe generator. Drives NUM_PIPES obstacle pipes scrolling right-to-left at a per-frame speed.
- Respawns each pipe with exact spacing and an LFSR-derived gap height.
- Emits score pulses and a pass count, and optionally ramps speed with score.
- Sits between the frame-timing logic and the collision/render blocks of the game core.

Parameters:
NUM_PIPES, 3, number of pipes (2..8)
X_W, 12, width of X/Y coordinate fields
PIPE_START_X, 600, initial left edge of pipe 0
PIPE_DIST, 300, horizontal spacing between consecutive pipes
PIPE_W, 80, pipe width in pixels
BIRD_X, 300, bird X position; pass threshold TH = BIRD_X - PIPE_W
GAP_MIN, 200, minimum gap-centre Y
GAP_RANGE, 300, gap-centre spread; legal range 256..511
SPEED_INIT, 3, pixels moved per frame at start of a game
SPEED_MAX, 8, speed ceiling (used only with ramp feature)
SCORE_PER_LEVEL, 5, passes per speed increment (used only with ramp feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
game_active  in  1  high while a game is running
frame_en  in  1  one-clk frame strobe
seed_load  in  1  load seed into LFSR
seed  in  16  LFSR seed value
pipe_x  out  NUM_PIPES*X_W  packed left-edge X; pipe i occupies bits [i*X_W +: X_W]
pipe_gap_y  out  NUM_PIPES*X_W  packed gap-centre Y, same packing
score_pulse  out  1  one-clk pulse when at least one pipe passes TH
pass_count  out  4  number of pipes passing TH in the frame that raised score_pulse
speed  out  4  current speed

Behaviour:
- Reset values (rst high on a clk edge):
  - pipe i x = PIPE_START_X + i*PIPE_DIST.
  - All gaps = GAP_MIN + (GAP_RANGE>>1).
  - score_pulse = 0, pass_count = 0, speed = SPEED_INIT.
  - LFSR = 16'hACE1; pass counter = 0; state = IDLE.
  - rst dominates all other inputs.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; shifts left, feedback into bit 0.
  - Advances on every frame_en, independent of state.
  - seed_load loads seed, or 16'hACE1 if seed == 0.
  - seed_load wins over a coincident frame_en.
- States:
  - IDLE → RUN when game_active = 1 (takes effect on the next frame_en).
  - RUN → IDLE on any clk where game_active = 0.
  - Entering IDLE restores the reset layout for x, gaps, speed and the pass counter. The LFSR is not restored.
- RUN, on a frame_en cycle, per pipe i (all pipes in parallel):
  - If x < speed: x ← x + NUM_PIPES*PIPE_DIST − speed, computed in X_W+1 bits. This is a respawn that preserves exact spacing.
    - On respawn, gap ← GAP_MIN + r.
    - v = bits [8:0] of the LFSR rotated left by 3*i.
    - r = v − GAP_RANGE if v ≥ GAP_RANGE, else v.
  - Else x ← x − speed.
- Scoring:
  - Pipe i passes when old x ≥ TH and new x < TH. A respawning pipe never passes.
  - score_pulse = 1 for exactly the clk after frame_en if any pipe passes; pass_count = number passing. Both are 0 on every other clk.
  - pass_count holds its value only during the pulse cycle.
- No outputs change except on frame_en, rst, or the IDLE restore.
- frame_en while rst is asserted is ignored.
- Widths: every sum is evaluated in X_W+1 bits and truncated to X_W. Parameters must keep all values < 2^X_W.

Optional Feature:
- Macro: PIPE_GEN_SPEED_RAMP_EN.
- Defined:
  - The pass counter accumulates pass_count.
  - On each crossing of a multiple of SCORE_PER_LEVEL, speed increments by 1, saturating at SPEED_MAX.
  - The new speed applies from the next frame.
  - Speed returns to SPEED_INIT on rst or IDLE.
- Undefined:
  - speed is constant at SPEED_INIT.
  - No pass-counter register is synthesised.

Test Plan:
- Reset: rst high 2 clks → pipe_x = {600,900,1200}, gaps all 350, speed = 3, score_pulse = 0.
- RUN, one frame_en → pipe_x = {597,897,1197}. Score after 127th frame_en → pipe 0 at 219 (was 222), score_pulse high for exactly 1 clk, pass_count = 1.
- Respawn: pipe 0 at x = 0 (after 200 frames), next frame_en → x = 897 while pipe 1 = 297 and pipe 2 = 597 (spacing 300 kept). New gap lies in 200..499 and matches the formula for the current LFSR.
- game_active dropped mid-game at an arbitrary frame → next clk the layout returns to {600,900,1200} and speed = 3. LFSR keeps running; with seed_load and seed = 0, LFSR = ACE1.
- With PIPE_GEN_SPEED_RAMP_EN: 5th pass → speed 4 from the next frame. Continue until speed saturates at 8, with no further change.
- frame_en asserted on the same clk as rst → every output keeps its reset value.
